// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Function : 4-digit common-anode 7-segment scanner, frame-aligned updates
// Revision : 1.0
// ============================================================================
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       neg,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int               c_CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       c_SEG_MINUS = 7'b0111111;
    localparam logic [6:0]       c_SEG_ERR   = 7'b0000110;

    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2,
        DIG_SIGN     = 2'd3
    } digit_e;

    logic [c_CNT_W-1:0] r_cnt;
    digit_e             r_digit;
    digit_e             w_digit_next;
    logic               w_cnt_term;
    logic               w_frame_wrap;

    logic [3:0]         r_cap_hundreds;
    logic [3:0]         r_cap_tens;
    logic [3:0]         r_cap_ones;
    logic               r_cap_neg;
    logic [3:0]         r_disp_hundreds;
    logic [3:0]         r_disp_tens;
    logic [3:0]         r_disp_ones;
    logic               r_disp_neg;
    logic               r_pending;

    logic [3:0]         w_digit_val;
    logic               w_blank;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_an_next;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = c_SEG_ERR;
        endcase
        return g;
    endfunction

    assign w_cnt_term   = (r_cnt == c_CNT_LAST);
    assign w_frame_wrap = w_cnt_term && (r_digit == DIG_SIGN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= DIG_ONES;
        end else begin
            r_digit <= w_digit_next;
        end
    end

    always_comb begin
        w_digit_next = r_digit;
        if (w_cnt_term) begin
            case (r_digit)
                DIG_ONES:     w_digit_next = DIG_TENS;
                DIG_TENS:     w_digit_next = DIG_HUNDREDS;
                DIG_HUNDREDS: w_digit_next = DIG_SIGN;
                DIG_SIGN:     w_digit_next = DIG_ONES;
                default:      w_digit_next = DIG_ONES;
            endcase
        end
    end

    // A load coinciding with the wrap bypasses the capture stage so it lands this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_hundreds  <= 4'd0;
            r_cap_tens      <= 4'd0;
            r_cap_ones      <= 4'd0;
            r_cap_neg       <= 1'b0;
            r_disp_hundreds <= 4'd0;
            r_disp_tens     <= 4'd0;
            r_disp_ones     <= 4'd0;
            r_disp_neg      <= 1'b0;
            r_pending       <= 1'b0;
        end else begin
            if (load) begin
                r_cap_hundreds <= hundreds;
                r_cap_tens     <= tens;
                r_cap_ones     <= ones;
                r_cap_neg      <= neg;
            end
            if (w_frame_wrap && load) begin
                r_disp_hundreds <= hundreds;
                r_disp_tens     <= tens;
                r_disp_ones     <= ones;
                r_disp_neg      <= neg;
                r_pending       <= 1'b0;
            end else if (w_frame_wrap && r_pending) begin
                r_disp_hundreds <= r_cap_hundreds;
                r_disp_tens     <= r_cap_tens;
                r_disp_ones     <= r_cap_ones;
                r_disp_neg      <= r_cap_neg;
                r_pending       <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Blanking only ever applies to a zero digit, so non-BCD codes always show 'E'.
    always_comb begin
        w_digit_val = r_disp_ones;
        w_blank     = 1'b0;
        w_seg_next  = c_SEG_BLANK;
        case (r_digit)
            DIG_ONES: begin
                w_digit_val = r_disp_ones;
            end
            DIG_TENS: begin
                w_digit_val = r_disp_tens;
                w_blank     = BLANK_EN && (r_disp_hundreds == 4'd0) && (r_disp_tens == 4'd0);
            end
            DIG_HUNDREDS: begin
                w_digit_val = r_disp_hundreds;
                w_blank     = BLANK_EN && (r_disp_hundreds == 4'd0);
            end
            default: begin
                w_digit_val = r_disp_ones;
            end
        endcase
        if (r_digit == DIG_SIGN) begin
            w_seg_next = r_disp_neg ? c_SEG_MINUS : c_SEG_BLANK;
        end else if (w_blank) begin
            w_seg_next = c_SEG_BLANK;
        end else begin
            w_seg_next = f_glyph(w_digit_val);
        end
    end

    assign w_an_next = ~(4'b0001 << r_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= c_SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign frame_tick = w_frame_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Function : Directed scoreboard bench for seg7_scan_driver (REFRESH_DIV=4)
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       neg;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;
    logic [3:0] an_nb;
    logic [6:0] seg_nb;
    logic       dp_nb;
    logic       frame_tick_nb;

    int          checks = 0;
    int          errors = 0;
    int          p = 0;
    logic [10:0] sb_q[$];
    logic [10:0] cur_exp = '0;
    logic        cur_valid = 1'b0;
    logic [3:0]  prev_an = 4'b1111;

    seg7_scan_driver #(.REFRESH_DIV(c_DIV), .BLANK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .hundreds(hundreds), .tens(tens),
        .ones(ones), .neg(neg), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(.REFRESH_DIV(c_DIV), .BLANK_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .load(load), .hundreds(hundreds), .tens(tens),
        .ones(ones), .neg(neg), .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_tick(frame_tick_nb)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    // Queue the expected {an,seg} of the first ndig digits of one frame (blanking on).
    task automatic push_frame(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                              input logic n, input int ndig);
        logic [10:0] e[4];
        e[0] = {4'b1110, glyph(o)};
        e[1] = {4'b1101, (h == 4'd0 && t == 4'd0) ? 7'b1111111 : glyph(t)};
        e[2] = {4'b1011, (h == 4'd0) ? 7'b1111111 : glyph(h)};
        e[3] = {4'b0111, n ? 7'b0111111 : 7'b1111111};
        for (int i = 0; i < ndig; i++) sb_q.push_back(e[i]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Pops a new expectation whenever a new digit starts, then holds it for the digit's duration.
    task automatic sample();
        if (rst_n === 1'b1 && an !== 4'b1111) begin
            if (an !== prev_an) begin
                checks++;
                assert (sb_q.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_underflow t=%0t observed an=%b seg=%b expected=queued digit", $time, an, seg);
                end
                cur_valid = (sb_q.size() > 0);
                if (cur_valid) cur_exp = sb_q.pop_front();
            end
            if (cur_valid) begin
                checks++;
                assert ({an, seg} === cur_exp) else begin
                    errors++;
                    $error("FAIL scan_digit t=%0t observed an=%b seg=%b expected an=%b seg=%b",
                           $time, an, seg, cur_exp[10:7], cur_exp[6:0]);
                end
            end
        end
        prev_an = an;
    endtask

    task automatic goto(input int target);
        while (p < target) begin
            @(negedge clk);
            p++;
            sample();
        end
    endtask

    task automatic drive_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                              input logic n);
        hundreds = h;
        tens     = t;
        ones     = o;
        neg      = n;
        load     = 1'b1;
        goto(p + 1);
        load     = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        neg      = 1'b0;
        goto(3);
        chk("rst_an", 32'(an), 32'(4'b1111));
        chk("rst_seg", 32'(seg), 32'(7'b1111111));
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pending", 32'(dut.r_pending), 32'd0);

        // Frames 0 and 1 show "   0"; a mid-frame load in frame 1 must not tear it.
        push_frame(4'd0, 4'd0, 4'd0, 1'b0, 4);
        push_frame(4'd0, 4'd0, 4'd0, 1'b0, 4);
        rst_n = 1'b1;
        p = 0;
        goto(6);
        chk("nb_tens_an", 32'(an_nb), 32'(4'b1101));
        chk("nb_tens_zero", 32'(seg_nb), 32'(7'b1000000));
        goto(10);
        chk("nb_hund_zero", 32'(seg_nb), 32'(7'b1000000));
        goto(14);
        chk("tick_pre", 32'(frame_tick), 32'd0);
        goto(15);
        chk("tick_wrap", 32'(frame_tick), 32'd1);
        goto(16);
        chk("tick_post", 32'(frame_tick), 32'd0);

        goto(21);
        drive_load(4'd1, 4'd2, 4'd7, 1'b0);
        push_frame(4'd1, 4'd2, 4'd7, 1'b0, 4);

        goto(37);
        drive_load(4'd0, 4'd0, 4'd5, 1'b1);
        push_frame(4'd0, 4'd0, 4'd5, 1'b1, 4);
        goto(50);
        chk("nb_ones5", 32'(seg_nb), 32'(7'b0010010));
        goto(54);
        chk("nb_tens_an3", 32'(an_nb), 32'(4'b1101));
        chk("nb_tens0", 32'(seg_nb), 32'(7'b1000000));
        goto(58);
        chk("nb_hund0", 32'(seg_nb), 32'(7'b1000000));
        goto(62);
        chk("nb_minus", 32'(seg_nb), 32'(7'b0111111));

        // Load landing exactly on the wrap edge.
        goto(63);
        chk("tick_wrap3", 32'(frame_tick), 32'd1);
        drive_load(4'd9, 4'd9, 4'd9, 1'b0);
        chk("pending_after_wrap_load", 32'(dut.r_pending), 32'd0);
        push_frame(4'd9, 4'd9, 4'd9, 1'b0, 4);

        goto(66);
        drive_load(4'd3, 4'd3, 4'd3, 1'b0);
        chk("pending_set", 32'(dut.r_pending), 32'd1);
        goto(70);
        drive_load(4'd4, 4'd4, 4'd4, 1'b0);
        push_frame(4'd4, 4'd4, 4'd4, 1'b0, 4);

        goto(82);
        drive_load(4'd0, 4'd0, 4'hC, 1'b0);
        push_frame(4'd0, 4'd0, 4'hC, 1'b0, 4);
        push_frame(4'd0, 4'd0, 4'hC, 1'b0, 2);

        // Pending load that reset must discard.
        goto(114);
        drive_load(4'd8, 4'd8, 4'd8, 1'b0);
        goto(118);
        rst_n = 1'b0;
        #1;
        chk("midrst_an", 32'(an), 32'(4'b1111));
        chk("midrst_seg", 32'(seg), 32'(7'b1111111));
        chk("midrst_tick", 32'(frame_tick), 32'd0);
        chk("midrst_pending", 32'(dut.r_pending), 32'd0);
        goto(121);
        push_frame(4'd0, 4'd0, 4'd0, 1'b0, 4);
        push_frame(4'd0, 4'd0, 4'd0, 1'b0, 4);
        rst_n = 1'b1;
        p = 0;
        goto(15);
        chk("tick_after_rst", 32'(frame_tick), 32'd1);
        chk("pending_after_rst", 32'(dut.r_pending), 32'd0);
        goto(32);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
